// File: rtl/cache_array_pkg.sv
// Shared types and helpers for the set-associative way array and its PLRU tree.
package cache_array_pkg;

    localparam int MAX_WAYS = 8;

    // Sized for the widest supported array; narrower arrays keep their unused upper nodes at 0.
    typedef logic [MAX_WAYS-2:0] plru_t;

    typedef enum logic {
        IDLE,
        SWEEP
    } sweep_state_t;

    function automatic int way_bits(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/cache_way_array_plru_tree.sv
// Tree pseudo-LRU: next state after touching a way, and the victim the current state points at.
// Nodes are in heap order (root = bit 0, children of n at 2n+1 / 2n+2); a 0 node points left/lower.
module plru_tree
    import cache_array_pkg::*;
#(
    parameter  int NUM_WAYS = 2,
    localparam int WB       = way_bits(NUM_WAYS)
) (
    input  plru_t         plru,
    input  logic [WB-1:0] touch_way,
    output plru_t         plru_next,
    output logic [WB-1:0] victim
);

    // Every node on the touched path is turned to point away from the touched way.
    always_comb begin
        int node;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        plru_next = plru;
        node      = 0;
        for (int l = 0; l < WB; l++) begin
            plru_next[node] = ~touch_way[WB-1-l];
            node            = 2 * node + 1 + int'(touch_way[WB-1-l]);
        end
    end

    always_comb begin
        int node;
        victim = '0;
        node   = 0;
        for (int l = 0; l < WB; l++) begin
            victim[WB-1-l] = plru[node];
            node           = 2 * node + 1 + int'(plru[node]);
        end
    end

endmodule

// File: rtl/cache_way_array.sv
// N-way set-associative data/valid/replacement store: registered read of all ways,
// per-set tree pseudo-LRU victim selection and a one-set-per-cycle invalidate-all sweep.
module cache_way_array
    import cache_array_pkg::*;
#(
    parameter  int S_INDEX  = 3,
    parameter  int WIDTH    = 128,
    parameter  int NUM_WAYS = 2,
    localparam int NUM_SETS = 2 ** S_INDEX,
    localparam int WB       = way_bits(NUM_WAYS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read,
    input  logic [S_INDEX-1:0]        index,
    output logic [NUM_WAYS*WIDTH-1:0] rdata,
    output logic [NUM_WAYS-1:0]       rvalid,
    input  logic                      load,
    input  logic [WB-1:0]             load_way,
    input  logic [WIDTH-1:0]          datain,
    input  logic                      touch,
    input  logic [WB-1:0]             touch_way,
    output logic [WB-1:0]             lru_way,
    input  logic                      inval_all,
    output logic                      busy
);

    localparam logic [S_INDEX:0] LAST_SET = (S_INDEX + 1)'(NUM_SETS - 1);

    logic [WIDTH-1:0]    data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    plru_t               plru_q  [NUM_SETS];

    sweep_state_t     state_q, state_d;
    logic [S_INDEX:0] count_q;
    logic             idle, load_en, touch_en, read_en, sweep_done;
    plru_t            plru_next;
    logic [WB-1:0]    victim;

    assign idle       = (state_q == IDLE);
    assign busy       = !idle;
    assign load_en    = load && idle && !inval_all;
    assign touch_en   = touch && idle;
    assign read_en    = read && idle;
    assign sweep_done = (count_q == LAST_SET);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inval_all)  state_d = SWEEP;
            SWEEP:   if (sweep_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter idles at 0, so every sweep starts from set 0.
    always_ff @(posedge clk) begin
        if (rst || idle) count_q <= '0;
        else             count_q <= count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (!idle) begin
            valid_q[count_q[S_INDEX-1:0]] <= '0;
            plru_q[count_q[S_INDEX-1:0]]  <= '0;
        end else begin
            if (load_en)  valid_q[index][load_way] <= 1'b1;
            if (touch_en) plru_q[index]            <= plru_next;
        end
    end

    // NOTE: the data array has no reset; valid bits alone decide whether an entry means anything.
    always_ff @(posedge clk) begin
        if (load_en) data_q[index][load_way] <= datain;
    end

    plru_tree #(
        .NUM_WAYS(NUM_WAYS)
    ) u_plru (
        .plru      (plru_q[index]),
        .touch_way (touch_way),
        .plru_next (plru_next),
        .victim    (victim)
    );

    // Scanning downwards leaves the lowest-numbered invalid way as the final choice.
    always_comb begin
        lru_way = victim;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[index][w]) lru_way = WB'(w);
        end
    end

    // Invalid ways read as zero so uninitialised storage never reaches the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= '0;
        end else begin
            rdata  <= '0;
            rvalid <= '0;
            if (read_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (load_en && load_way == WB'(w)) begin
                        rdata[w*WIDTH +: WIDTH] <= datain;
                        rvalid[w]               <= 1'b1;
                    end else begin
                        rdata[w*WIDTH +: WIDTH] <= valid_q[index][w] ? data_q[index][w] : '0;
                        rvalid[w]               <= valid_q[index][w];
                    end
                end
            end
        end
    end

endmodule
